frame_buffer: RTL and testbench

Double-buffered pixel store that sits on the receiving end of the GPU's framebuffer write port (x, y, color, write strobe) and on the sending end of the display scan-out stream. The GPU draws into the back buffer while the front buffer is streamed pixel by pixel, row-major, to the video output stage over a valid/ready handshake. A swap request flips front and back only at a frame boundary, so the display never shows a half-drawn frame.

---
 rtl/frame_buffer_pkg.sv | 25 ++
 rtl/frame_buffer_if.sv | 35 +++
 rtl/fb_bank.sv | 24 ++
 rtl/frame_buffer.sv | 164 ++++++++++++++++
 tb/tb_frame_buffer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_buffer_pkg.sv
// Shared types and frame geometry defaults for the double-buffered frame store.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package frame_buffer_pkg;

  // Frame geometry defaults, shared with the GPU side.
  localparam int FB_WIDTH_DEFAULT  = 400;
  localparam int FB_HEIGHT_DEFAULT = 240;

  // RGB5551 pixel; the low bit is kept verbatim, no transparency handling.
  localparam int PIX_W = 16;

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // One scan-out FIFO entry: pixel plus its framing tags.
  typedef struct packed {
    logic [PIX_W-1:0] color;
    logic             sof;
    logic             eol;
  } pix_t;

endpackage

// File: rtl/frame_buffer_if.sv
// GPU write port, swap control and scan-out stream of the frame store.
// Latency: n/a (wiring only).
// Backpressure: out_valid/out_ready handshake on the scan-out side.
interface frame_buffer_if #(
  parameter int FB_WIDTH  = 400,
  parameter int FB_HEIGHT = 240
);
  localparam int XW = $clog2(FB_WIDTH) + 1;
  localparam int YW = $clog2(FB_HEIGHT) + 1;

  logic [XW-1:0] fb_x;
  logic [YW-1:0] fb_y;
  logic [15:0]   fb_color;
  logic          fb_write;
  logic          ctrl_swap;
  logic          swap_pending;
  logic          swap_done;
  logic [15:0]   out_color;
  logic          out_sof;
  logic          out_eol;
  logic          out_valid;
  logic          out_ready;

  // Drives writes/swaps and consumes the scan-out stream.
  modport master (
    output fb_x, fb_y, fb_color, fb_write, ctrl_swap, out_ready,
    input  swap_pending, swap_done, out_color, out_sof, out_eol, out_valid
  );

  // The frame buffer itself.
  modport slave (
    input  fb_x, fb_y, fb_color, fb_write, ctrl_swap, out_ready,
    output swap_pending, swap_done, out_color, out_sof, out_eol, out_valid
  );
endinterface

// File: rtl/fb_bank.sv
// Simple dual-port RAM bank: one write port, one registered read port.
// Latency: read data valid 1 cycle after re; write visible to reads next cycle.
// Backpressure: none; contents are never reset.
module fb_bank #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Write port and registered read port; rdata holds when re is low.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/frame_buffer.sv
// Double-buffered pixel store: GPU writes the back bank, front bank streams out row-major.
// Latency: first pixel 2 cycles after reset release, then 1 pixel/cycle.
// Backpressure: out_* held while valid && !ready; reads stop within 1 cycle via a 2-entry skid FIFO.
module frame_buffer
  import frame_buffer_pkg::*;
#(
  parameter int FB_WIDTH  = FB_WIDTH_DEFAULT,
  parameter int FB_HEIGHT = FB_HEIGHT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  frame_buffer_if.slave bus
);
  localparam int NPIX = FB_WIDTH * FB_HEIGHT;
  localparam int AW   = $clog2(NPIX);
  localparam int XW   = $clog2(FB_WIDTH) + 1;
  localparam int YW   = $clog2(FB_HEIGHT) + 1;
  localparam int CXW  = (FB_WIDTH > 1) ? $clog2(FB_WIDTH) : 1;
  localparam int CYW  = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;

  logic             front;
  swap_state_t      swap_state;
  logic             swap_prev;
  logic             swap_done_q;
  logic [CXW-1:0]   rd_x;
  logic [CYW-1:0]   rd_y;
  logic             inflight;
  logic             rd_bank;
  logic             tag_sof;
  logic             tag_eol;
  pix_t             fifo_mem [2];
  logic             fifo_wr_ptr;
  logic             fifo_rd_ptr;
  logic [1:0]       fifo_count;
  logic [PIX_W-1:0] rdata0;
  logic [PIX_W-1:0] rdata1;

  logic             wr_ok;
  logic [AW-1:0]    wr_addr;
  logic [AW-1:0]    rd_addr;
  logic             last_x;
  logic             last_y;
  logic             out_vld;
  logic             pop;
  logic [2:0]       occupancy;
  logic             issue;
  logic             swap_edge;
  logic             flip;
  pix_t             head;
  pix_t             push_dat;

  // Out-of-range coordinates are dropped; the target bank is the current back bank.
  assign wr_ok   = bus.fb_write && (bus.fb_x < XW'(FB_WIDTH)) && (bus.fb_y < YW'(FB_HEIGHT));
  assign wr_addr = AW'(int'(bus.fb_y) * FB_WIDTH + int'(bus.fb_x));

  assign rd_addr = AW'(int'(rd_y) * FB_WIDTH + int'(rd_x));
  assign last_x  = (rd_x == CXW'(FB_WIDTH - 1));
  assign last_y  = (rd_y == CYW'(FB_HEIGHT - 1));

  // Occupancy counts the entry leaving this cycle as gone, so a full-rate
  // stream keeps issuing while a stall can never overflow the 2-entry FIFO.
  assign out_vld   = (fifo_count != 2'd0);
  assign pop       = out_vld && bus.out_ready;
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (occupancy < 3'd2);

  // Flip only when the last pixel of the frame is actually issued.
  assign swap_edge = bus.ctrl_swap && !swap_prev;
  assign flip      = issue && last_x && last_y && ((swap_state == SWAP_PENDING) || swap_edge);

  fb_bank #(.DEPTH(NPIX), .WIDTH(PIX_W)) u_bank0 (
    .clk   (clk),
    .we    (wr_ok && front),
    .waddr (wr_addr),
    .wdata (bus.fb_color),
    .re    (issue && !front),
    .raddr (rd_addr),
    .rdata (rdata0)
  );

  fb_bank #(.DEPTH(NPIX), .WIDTH(PIX_W)) u_bank1 (
    .clk   (clk),
    .we    (wr_ok && !front),
    .waddr (wr_addr),
    .wdata (bus.fb_color),
    .re    (issue && front),
    .raddr (rd_addr),
    .rdata (rdata1)
  );

  assign push_dat.color = rd_bank ? rdata1 : rdata0;
  assign push_dat.sof   = tag_sof;
  assign push_dat.eol   = tag_eol;

  // Swap FSM: capture a rising ctrl_swap edge, flip front at the frame boundary.
  always_ff @(posedge clk) begin
    if (!reset) begin
      swap_prev   <= 1'b0;
      swap_state  <= SWAP_IDLE;
      front       <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      swap_prev   <= bus.ctrl_swap;
      swap_done_q <= flip;
      if (flip) begin
        front      <= !front;
        swap_state <= SWAP_IDLE;
      end else if (swap_edge) begin
        swap_state <= SWAP_PENDING;
      end
    end
  end

  // Row-major scan counters; framing tags and bank select travel with each read.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_x     <= '0;
      rd_y     <= '0;
      inflight <= 1'b0;
      rd_bank  <= 1'b0;
      tag_sof  <= 1'b0;
      tag_eol  <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        rd_bank <= front;
        tag_sof <= (rd_x == '0) && (rd_y == '0);
        tag_eol <= last_x;
        if (last_x) begin
          rd_x <= '0;
          rd_y <= last_y ? '0 : rd_y + CYW'(1);
        end else begin
          rd_x <= rd_x + CXW'(1);
        end
      end
    end
  end

  // 2-entry output FIFO; RAM data returning this cycle is always pushed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_wr_ptr <= 1'b0;
      fifo_rd_ptr <= 1'b0;
      fifo_count  <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_mem[fifo_wr_ptr] <= push_dat;
        fifo_wr_ptr           <= !fifo_wr_ptr;
      end
      if (pop) fifo_rd_ptr <= !fifo_rd_ptr;
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  assign head             = fifo_mem[fifo_rd_ptr];
  assign bus.out_color    = head.color;
  assign bus.out_sof      = head.sof;
  assign bus.out_eol      = head.eol;
  assign bus.out_valid    = out_vld;
  assign bus.swap_pending = (swap_state == SWAP_PENDING);
  assign bus.swap_done    = swap_done_q;
endmodule

// File: tb/tb_frame_buffer.sv
// Scoreboard bench for frame_buffer on a 4x3 frame.
// Stimulus drives at posedge+1, monitor samples at negedge.
// Ready patterns: constant, 1,0,0,1,0 and random.
module tb_frame_buffer;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct packed {
    logic [15:0] color;
    logic        sof;
    logic        eol;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  frame_buffer_if #(.FB_WIDTH(W), .FB_HEIGHT(H)) fb_if ();

  frame_buffer #(.FB_WIDTH(W), .FB_HEIGHT(H)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (fb_if)
  );

  exp_t        exp_q [$];
  logic [15:0] bank_m [2][N];
  int          front_m = 0;
  int          tests = 0;
  int          fails = 0;
  int          acc_cnt = 0;
  int          done_cnt = 0;
  int          model_swaps = 0;
  int          ready_mode = 0;
  int          pat_idx = 0;
  logic [4:0]  ready_pat = 5'b01001;
  logic        prev_stall = 1'b0;
  logic        prev_done = 1'b0;
  exp_t        prev_dat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame from the model's current front bank.
  task automatic push_frame();
    for (int p = 0; p < N; p++) begin
      exp_t e;
      e.color = bank_m[front_m][p];
      e.sof   = (p == 0);
      e.eol   = ((p % W) == W - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic end_frame(input bit swapped);
    if (swapped) begin
      front_m = 1 - front_m;
      model_swaps++;
    end
    push_frame();
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 3000 && acc_cnt < target; i++) tick();
    if (acc_cnt < target) begin
      tests++;
      fails++;
      $display("FAIL wait_acc: accepted %0d, required %0d", acc_cnt, target);
      finish_run();
    end
  endtask

  // Wait until the pixel with stream index target is on the output.
  task automatic wait_present(input int target);
    for (int i = 0; i < 3000 && !(fb_if.out_valid && acc_cnt == target); i++) tick();
    if (!(fb_if.out_valid && acc_cnt == target)) begin
      tests++;
      fails++;
      $display("FAIL wait_present: accepted %0d, required %0d", acc_cnt, target);
      finish_run();
    end
  endtask

  task automatic gpu_write(input int x, input int y, input logic [15:0] c);
    fb_if.fb_x     = 3'(x);
    fb_if.fb_y     = 3'(y);
    fb_if.fb_color = c;
    fb_if.fb_write = 1'b1;
    if (x < W && y < H) bank_m[1 - front_m][y * W + x] = c;
    tick();
    fb_if.fb_write = 1'b0;
  endtask

  task automatic rand_writes(input int n);
    for (int i = 0; i < n; i++) begin
      int x, y;
      x = ($urandom_range(0, 3) != 0) ? $urandom_range(0, W - 1) : $urandom_range(0, 7);
      y = ($urandom_range(0, 3) != 0) ? $urandom_range(0, H - 1) : $urandom_range(0, 7);
      gpu_write(x, y, 16'($urandom));
    end
  endtask

  task automatic swap_req();
    fb_if.ctrl_swap = 1'b1;
    tick();
    check("swap_pending_set", 32'(fb_if.swap_pending), 32'd1);
    fb_if.ctrl_swap = 1'b0;
    tick();
  endtask

  // Sink ready driver.
  initial begin
    fb_if.out_ready = 1'b1;
    forever begin
      tick();
      case (ready_mode)
        0: fb_if.out_ready = 1'b1;
        1: begin
          fb_if.out_ready = ready_pat[pat_idx % 5];
          pat_idx++;
        end
        default: fb_if.out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: scoreboard pops, stall stability and swap_done pulse shape.
  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      acc_cnt    = 0;
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end else begin
      exp_t cur;
      cur = {fb_if.out_color, fb_if.out_sof, fb_if.out_eol};
      if (prev_stall) begin
        check("stall_valid", 32'(fb_if.out_valid), 32'd1);
        check("stall_hold", 32'(cur), 32'(prev_dat));
      end
      if (fb_if.swap_done) begin
        done_cnt++;
        check("swap_done_one_cycle", 32'(prev_done), 32'd0);
      end
      prev_done = fb_if.swap_done;
      if (fb_if.out_valid && fb_if.out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pixel: got %0h, required none", cur);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check($sformatf("pixel_%0d", acc_cnt), 32'(cur), 32'(e));
        end
        acc_cnt++;
      end
      prev_stall = fb_if.out_valid && !fb_if.out_ready;
      prev_dat   = cur;
    end
  end

  initial begin
    #500000;
    tests++;
    fails++;
    $display("FAIL watchdog: run still active, required finished");
    finish_run();
  end

  initial begin
    bit sw;
    for (int b = 0; b < 2; b++)
      for (int p = 0; p < N; p++) bank_m[b][p] = 16'h0000;
    fb_if.fb_x      = '0;
    fb_if.fb_y      = '0;
    fb_if.fb_color  = '0;
    fb_if.fb_write  = 1'b0;
    fb_if.ctrl_swap = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", 32'(fb_if.out_valid), 32'd0);
    check("rst_out_sof", 32'(fb_if.out_sof), 32'd0);
    check("rst_out_eol", 32'(fb_if.out_eol), 32'd0);
    check("rst_out_color", 32'(fb_if.out_color), 32'd0);
    check("rst_swap_pending", 32'(fb_if.swap_pending), 32'd0);
    check("rst_swap_done", 32'(fb_if.swap_done), 32'd0);
    tick();
    reset = 1'b1;
    push_frame();
    @(negedge clk);
    check("startup_cycle0_valid", 32'(fb_if.out_valid), 32'd0);
    @(negedge clk);
    check("startup_cycle1_valid", 32'(fb_if.out_valid), 32'd0);
    @(negedge clk);
    check("startup_cycle2_valid", 32'(fb_if.out_valid), 32'd1);
    tick();

    for (int f = 0; f < 15; f++) begin
      wait_acc(f * N + 1);
      sw = 1'b0;
      case (f)
        1: begin
          gpu_write(4, 0, 16'h1111);
          gpu_write(0, 3, 16'h2222);
          gpu_write(7, 7, 16'h3333);
        end
        2, 3, 6: begin
          swap_req();
          sw = 1'b1;
        end
        4: begin
          gpu_write(1, 2, 16'hABCD);
          swap_req();
          sw = 1'b1;
        end
        5, 9: rand_writes(3);
        7: begin
          ready_mode = 1;
          rand_writes(2);
        end
        8: begin
          rand_writes(3);
          swap_req();
          sw = 1'b1;
        end
        10, 11, 12: begin
          ready_mode = 2;
          rand_writes(3);
          if ($urandom_range(0, 1) == 1) begin
            swap_req();
            sw = 1'b1;
          end
        end
        13: begin
          // Swap edge in the very cycle the last pixel (3,2) is issued.
          ready_mode = 0;
          wait_present(f * N + 9);
          fb_if.ctrl_swap = 1'b1;
          tick();
          check("boundary_pending_low", 32'(fb_if.swap_pending), 32'd0);
          check("boundary_swap_done", 32'(fb_if.swap_done), 32'd1);
          fb_if.ctrl_swap = 1'b0;
          sw = 1'b1;
        end
        default: ;
      endcase
      end_frame(sw);
    end

    // Frame 15: pending swap, then reset while pixel 6 is on the output.
    wait_acc(15 * N + 1);
    swap_req();
    wait_present(15 * N + 6);
    reset = 1'b0;
    tick();
    check("midrst_out_valid", 32'(fb_if.out_valid), 32'd0);
    check("midrst_swap_pending", 32'(fb_if.swap_pending), 32'd0);
    reset = 1'b1;
    front_m = 0;
    push_frame();
    wait_acc(1);
    push_frame();
    wait_acc(2 * N);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("swap_done_count", 32'(done_cnt), 32'(model_swaps));
    finish_run();
  end
endmodule
